// File: rtl/weight_stream_buffer.sv
// Weight stream buffer: pops coefficients from the weight FIFO into a
// ping-pong pair of kernel banks and exposes the completed bank to the
// convolution datapath through a registered random-access read port.
module weight_stream_buffer #(
    parameter int COEFF_WIDTH = 16,
    parameter int KERN_S      = 9,
    localparam int ADDR_W     = $clog2(KERN_S)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [COEFF_WIDTH-1:0] input_V_dout,
    input  logic                   input_V_empty_n,
    output logic                   input_V_read,
    output logic                   bank_valid,
    input  logic                   bank_release,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [COEFF_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    bank_state_t bank_st     [2];
    bank_state_t bank_st_nxt [2];

    logic              wr_bank, wr_bank_nxt;
    logic              rd_bank, rd_bank_nxt;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_nxt;

    // Coefficient storage is data only; it carries no reset.
    logic [COEFF_WIDTH-1:0] mem [2][KERN_S];

    logic pop;
    logic last_word;
    logic release_ok;
    logic rd_in_range;

    // A full write bank means both banks are full, so popping must stall.
    // The reset term keeps the pop strobe low while the block is held in reset.
    assign input_V_read = ap_rst_n && input_V_empty_n && (bank_st[wr_bank] != BANK_FULL);
    assign pop          = input_V_read;
    assign last_word    = (wr_cnt == ADDR_W'(KERN_S - 1));
    assign bank_valid   = (bank_st[rd_bank] == BANK_FULL);
    assign release_ok   = bank_release && bank_valid;
    assign rd_in_range  = (32'(rd_addr) < 32'(KERN_S));

    // Next-state decode: fill and release always target different banks,
    // so both updates can be applied in the same cycle without conflict.
    always_comb begin
        bank_st_nxt = bank_st;
        wr_bank_nxt = wr_bank;
        wr_cnt_nxt  = wr_cnt;
        rd_bank_nxt = rd_bank;
        if (pop) begin
            if (last_word) begin
                bank_st_nxt[wr_bank] = BANK_FULL;
                wr_cnt_nxt           = '0;
                wr_bank_nxt          = ~wr_bank;
            end else begin
                bank_st_nxt[wr_bank] = BANK_FILLING;
                wr_cnt_nxt           = wr_cnt + 1'b1;
            end
        end
        if (release_ok) begin
            bank_st_nxt[rd_bank] = BANK_EMPTY;
            rd_bank_nxt          = ~rd_bank;
        end
    end

    // Control state register; reset discards any partial or complete kernel.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
            wr_bank    <= wr_bank_nxt;
            rd_bank    <= rd_bank_nxt;
            wr_cnt     <= wr_cnt_nxt;
        end
    end

    // Fill stage: each popped word lands at the next slot of the write bank.
    always_ff @(posedge ap_clk) begin
        if (pop) begin
            mem[wr_bank][wr_cnt] <= input_V_dout;
        end
    end

    // Read stage: one-cycle registered read from the pre-release read bank;
    // out-of-range addresses return zero, and the output holds without rd_en.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (rd_in_range) begin
                rd_data <= mem[rd_bank][rd_addr];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Testbench for weight_stream_buffer: FIFO source model, kernel-queue
// reference model, directed sequences, a read-port vector table and a
// randomized soak.
module tb_weight_stream_buffer;

    localparam int CW = 16;
    localparam int KS = 9;
    localparam int AW = $clog2(KS);

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [CW-1:0] input_V_dout;
    logic          input_V_empty_n;
    logic          input_V_read;
    logic          bank_valid;
    logic          bank_release;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;

    weight_stream_buffer #(.COEFF_WIDTH(CW), .KERN_S(KS)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .input_V_dout    (input_V_dout),
        .input_V_empty_n (input_V_empty_n),
        .input_V_read    (input_V_read),
        .bank_valid      (bank_valid),
        .bank_release    (bank_release),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference model: upstream FIFO contents, completed kernels oldest
    // first (the head is the read bank), and the kernel being assembled.
    typedef logic [KS*CW-1:0] kern_t;
    logic [CW-1:0] fifo [$];
    kern_t         kq   [$];
    logic [CW-1:0] part [$];
    logic          gate;
    logic [CW-1:0] exp_rd;
    bit            rd_known;
    bit            popped;
    int            npops;
    int            checks;
    int            errors;

    typedef struct {
        bit            rd_en;
        int            addr;
        bit            rel;
        bit            chk_rd;
        logic [CW-1:0] exp_rd;
        bit            exp_valid;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        input_V_empty_n = gate && (fifo.size() > 0);
        input_V_dout    = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) fifo.push_back(CW'(v));
        drive_fifo();
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic cyc();
        bit    pop;
        bit    rel;
        bit    rv;
        kern_t k;
        @(negedge ap_clk);
        check("input_V_read", 32'(input_V_read), 32'(input_V_empty_n && (kq.size() < 2)));
        check("bank_valid", 32'(bank_valid), 32'(kq.size() > 0));
        pop = input_V_read && input_V_empty_n;
        rv  = (kq.size() > 0);
        if (rd_en) begin
            if (int'(rd_addr) >= KS) begin
                exp_rd   = '0;
                rd_known = 1'b1;
            end else if (rv) begin
                k        = kq[0];
                exp_rd   = k[int'(rd_addr)*CW +: CW];
                rd_known = 1'b1;
            end else begin
                rd_known = 1'b0;
            end
        end
        rel = bank_release && rv;
        @(posedge ap_clk);
        #1;
        if (rel) void'(kq.pop_front());
        popped = pop;
        if (pop) begin
            npops++;
            part.push_back(fifo.pop_front());
            if (part.size() == KS) begin
                k = '0;
                for (int i = 0; i < KS; i++) k[i*CW +: CW] = part[i];
                kq.push_back(k);
                part.delete();
            end
        end
        if (rd_known) check("rd_data", 32'(rd_data), 32'(exp_rd));
        drive_fifo();
    endtask

    // Reset asserted at posedge+1; outputs must clear immediately.
    task automatic do_reset();
        ap_rst_n = 1'b0;
        #1;
        check("rst_bank_valid", 32'(bank_valid), 32'd0);
        check("rst_input_V_read", 32'(input_V_read), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        kq.delete();
        part.delete();
        fifo.delete();
        exp_rd       = '0;
        rd_known     = 1'b1;
        bank_release = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        gate         = 1'b1;
        npops        = 0;
        drive_fifo();
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic read_kernel(input string name, input int base);
        for (int i = 0; i < KS; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            cyc();
            check(name, 32'(rd_data), 32'(base + i));
        end
        rd_en = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        npops        = 0;
        gate         = 1'b1;
        bank_release = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        ap_rst_n     = 1'b0;
        drive_fifo();
        #1;

        // 1: back-to-back fill of 1..9, valid on the tenth cycle, reads 1..9.
        fifo.push_back(CW'(7));
        drive_fifo();
        do_reset();
        push_range(1, 9);
        for (int c = 0; c < 8; c++) cyc();
        check("t1_valid_before_last", 32'(bank_valid), 32'd0);
        cyc();
        check("t1_pops", 32'(npops), 32'd9);
        check("t1_valid_after_last", 32'(bank_valid), 32'd1);
        read_kernel("t1_read", 1);

        // 2: 1..19 with no release: 18 pops, word 19 stays in the FIFO.
        do_reset();
        push_range(1, 19);
        for (int c = 0; c < 22; c++) cyc();
        check("t2_pops", 32'(npops), 32'd18);
        check("t2_fifo_left", 32'(fifo.size()), 32'd1);
        check("t2_read_stalled", 32'(input_V_read), 32'd0);
        check("t2_valid", 32'(bank_valid), 32'd1);

        // 3: release one bank: valid stays up, word 19 pops after the bubble.
        bank_release = 1'b1;
        cyc();
        bank_release = 1'b0;
        check("t3_valid_after_release", 32'(bank_valid), 32'd1);
        check("t3_no_pop_in_release_cycle", 32'(popped), 32'd0);
        cyc();
        check("t3_pop_resumes", 32'(popped), 32'd1);
        check("t3_part_head", 32'(part[0]), 32'd19);
        read_kernel("t3_read", 10);

        // 4: empty_n toggling every cycle still fills 1..9 in order.
        do_reset();
        push_range(1, 9);
        begin
            int n = 0;
            while (!bank_valid && n < 40) begin
                gate = ~gate;
                drive_fifo();
                cyc();
                n++;
            end
            check("t4_fill_bounded", 32'(n <= 20 && n >= 17), 32'd1);
        end
        gate = 1'b1;
        drive_fifo();
        read_kernel("t4_read", 1);

        // 5: read-port vector table on a bank holding 1..9.
        vecs[0] = '{1'b1, 0,  1'b0, 1'b1, 16'd1, 1'b1};
        vecs[1] = '{1'b1, 8,  1'b0, 1'b1, 16'd9, 1'b1};
        vecs[2] = '{1'b1, KS, 1'b0, 1'b1, 16'd0, 1'b1};
        vecs[3] = '{1'b1, 15, 1'b0, 1'b1, 16'd0, 1'b1};
        vecs[4] = '{1'b0, 3,  1'b0, 1'b1, 16'd0, 1'b1};
        vecs[5] = '{1'b1, 4,  1'b1, 1'b1, 16'd5, 1'b0};
        vecs[6] = '{1'b0, 2,  1'b1, 1'b1, 16'd5, 1'b0};
        vecs[7] = '{1'b1, KS, 1'b0, 1'b1, 16'd0, 1'b0};
        vecs[8] = '{1'b0, 0,  1'b0, 1'b1, 16'd0, 1'b0};
        do_reset();
        push_range(1, 9);
        for (int c = 0; c < 10; c++) cyc();
        for (int i = 0; i < 9; i++) begin
            rd_en        = vecs[i].rd_en;
            rd_addr      = AW'(vecs[i].addr);
            bank_release = vecs[i].rel;
            cyc();
            if (vecs[i].chk_rd) check($sformatf("t5_vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            check($sformatf("t5_vec%0d_valid", i), 32'(bank_valid), 32'(vecs[i].exp_valid));
        end
        rd_en        = 1'b0;
        bank_release = 1'b0;

        // 6: reset after 5 pops discards the partial kernel; 20..28 refill bank 0.
        do_reset();
        push_range(1, 9);
        for (int c = 0; c < 5; c++) cyc();
        check("t6_pops_before_reset", 32'(npops), 32'd5);
        do_reset();
        push_range(20, 28);
        for (int c = 0; c < 10; c++) cyc();
        check("t6_valid", 32'(bank_valid), 32'd1);
        read_kernel("t6_read", 20);

        // Randomized soak against the kernel-queue model.
        for (int c = 0; c < 3000; c++) begin
            if (fifo.size() < 6 && $urandom_range(0, 3) != 0) fifo.push_back(CW'($urandom));
            gate         = ($urandom_range(0, 4) != 0);
            rd_en        = $urandom_range(0, 1) == 1;
            rd_addr      = AW'($urandom_range(0, (1 << AW) - 1));
            bank_release = ($urandom_range(0, 5) == 0);
            drive_fifo();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
